// File: rtl/dmem_arbiter_if.sv
// Shared bus between the data-memory arbiter, its two requesters and the SRAM.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [3:0]        ext_len;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_wready;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_done;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output ext_wready, ext_rvalid, ext_rdata, ext_done,
    output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  ext_wready, ext_rvalid, ext_rdata, ext_done,
    input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing the data SRAM between the core load/store port and
// the external burst port; core-first with bounded fairness for ext.
module dmem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int MAX_CORE_WINS = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_CORE_WINS < 1) ? 1 : $clog2(MAX_CORE_WINS + 1);
  localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(MAX_CORE_WINS);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_win_cnt, w_win_cnt_nxt;
  logic [3:0]        r_beat, w_beat_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_len;
  logic              r_we;
  logic              r_rd_vld, r_rd_ext;

  logic              w_core_gnt, w_ext_grant, w_ext_beat, w_beat_we;
  logic [ADDR_W-1:0] w_beat_addr;
  logic              w_mem_wen, w_mem_ren;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_ext_grant = 1'b0;
    w_core_gnt  = 1'b0;
    w_ext_beat  = 1'b0;
    w_beat_we   = r_we;
    w_beat_addr = r_base + ADDR_W'(r_beat);
    case (r_state)
      S_IDLE: begin
        if (bus.ext_req && (!bus.core_req || r_win_cnt == WIN_MAX)) begin
          w_ext_grant = 1'b1;
          w_ext_beat  = 1'b1;
          w_beat_we   = bus.ext_we;
          w_beat_addr = bus.ext_addr;
          w_beat_nxt  = 4'd1;
          w_state_nxt = (bus.ext_len == 4'd0) ? S_DONE : S_BURST;
        end else begin
          w_core_gnt = bus.core_req;
        end
      end
      S_BURST: begin
        w_ext_beat = 1'b1;
        w_beat_nxt = r_beat + 4'd1;
        if (r_beat == r_len) w_state_nxt = S_DONE;
      end
      // Burst finished: no ext beat, but the core may take this slot.
      S_DONE: begin
        w_core_gnt  = bus.core_req;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Fairness count only tracks core wins while ext is actually waiting in IDLE.
    w_win_cnt_nxt = r_win_cnt;
    if (r_state != S_IDLE || w_ext_grant || !bus.ext_req)
      w_win_cnt_nxt = '0;
    else if (w_core_gnt && r_win_cnt != WIN_MAX)
      w_win_cnt_nxt = r_win_cnt + CNT_W'(1);
  end

  assign w_mem_wen = (w_core_gnt && bus.core_we)  || (w_ext_beat && w_beat_we);
  assign w_mem_ren = (w_core_gnt && !bus.core_we) || (w_ext_beat && !w_beat_we);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_win_cnt <= '0;
      r_beat    <= 4'd0;
      r_rd_vld  <= 1'b0;
      r_rd_ext  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_win_cnt <= w_win_cnt_nxt;
      r_beat    <= w_beat_nxt;
      r_rd_vld  <= w_mem_ren;
      r_rd_ext  <= w_ext_beat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ext_grant) begin
      r_base <= bus.ext_addr;
      r_len  <= bus.ext_len;
      r_we   <= bus.ext_we;
    end
  end

  assign bus.core_gnt    = w_core_gnt;
  assign bus.ext_wready  = w_ext_beat && w_beat_we;
  assign bus.ext_done    = (r_state == S_DONE);

  assign bus.mem_wen     = w_mem_wen;
  assign bus.mem_ren     = w_mem_ren;
  assign bus.mem_waddr   = !w_mem_wen ? '0 : (w_ext_beat ? w_beat_addr : bus.core_addr);
  assign bus.mem_wdata   = !w_mem_wen ? '0 : (w_ext_beat ? bus.ext_wdata : bus.core_wdata);
  assign bus.mem_raddr   = !w_mem_ren ? '0 : (w_ext_beat ? w_beat_addr : bus.core_addr);

  // Read data is steered by the owner tag captured with the previous mem_ren.
  assign bus.core_rvalid = r_rd_vld && !r_rd_ext;
  assign bus.ext_rvalid  = r_rd_vld && r_rd_ext;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata   = bus.ext_rvalid  ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected writes and
// read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_CORE_WINS(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // SRAM model: 1-cycle read latency, preloaded with a known pattern
  logic [31:0] mem [256];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < 256; a++) mem[a] <= (a == 16) ? 32'hDEADBEEF : 32'h100 + 32'(a);
      bus.mem_rdata <= 32'd0;
      init_done     <= 1'b1;
    end else begin
      if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
      if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [39:0] wr_q [$];
  logic [31:0] core_q [$];
  logic [31:0] ext_q [$];
  logic run_mon = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected 0x%0h expected nothing (t=%0t)", nm, act, $time);
  endtask

  function automatic logic outs_or();
    return |{bus.core_gnt, bus.core_rvalid, bus.core_rdata, bus.ext_wready, bus.ext_rvalid,
             bus.ext_rdata, bus.ext_done, bus.mem_wen, bus.mem_waddr, bus.mem_wdata,
             bus.mem_ren, bus.mem_raddr};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (run_mon) begin
      logic [39:0] ew;
      logic [31:0] ed;
      chk("excl_wen_ren", 64'(bus.mem_wen & bus.mem_ren), 64'd0);
      if (bus.mem_wen) begin
        if (wr_q.size() == 0) unexpected("mem_write", {24'd0, bus.mem_waddr, bus.mem_wdata});
        else begin
          ew = wr_q.pop_front();
          chk("mem_write", {24'd0, bus.mem_waddr, bus.mem_wdata}, {24'd0, ew});
        end
      end
      if (bus.core_rvalid) begin
        chk("core_rv_ext_zero", 64'(bus.ext_rdata), 64'd0);
        if (core_q.size() == 0) unexpected("core_rdata", 64'(bus.core_rdata));
        else begin
          ed = core_q.pop_front();
          chk("core_rdata", 64'(bus.core_rdata), 64'(ed));
        end
      end
      if (bus.ext_rvalid) begin
        chk("ext_rv_core_zero", 64'(bus.core_rdata), 64'd0);
        if (ext_q.size() == 0) unexpected("ext_rdata", 64'(bus.ext_rdata));
        else begin
          ed = ext_q.pop_front();
          chk("ext_rdata", 64'(bus.ext_rdata), 64'(ed));
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_len = '0; bus.ext_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic core_load(input logic [7:0] addr, input logic [31:0] exp);
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = addr;
    @(negedge clk);
    chk("core_load_gnt", {bus.core_gnt, bus.mem_ren, bus.mem_raddr}, {1'b1, 1'b1, addr});
    core_q.push_back(exp);
    next_cycle();
    bus.core_req = 0;
    @(negedge clk);
    chk("core_load_rvalid", 64'(bus.core_rvalid), 64'd1);
    next_cycle();
  endtask

  logic [2:0] exp3;

  initial begin
    clear_inputs();
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(outs_or()), 64'd0);
    next_cycle();
    rst_n = 1;
    run_mon = 1;
    @(negedge clk);
    chk("idle_outs", 64'(outs_or()), 64'd0);
    next_cycle();

    // Core load from 0x10
    core_load(8'h10, 32'hDEADBEEF);

    // Ext write burst wrapping past the top of memory
    wr_q.push_back({8'hFE, 32'd1}); wr_q.push_back({8'hFF, 32'd2});
    wr_q.push_back({8'h00, 32'd3}); wr_q.push_back({8'h01, 32'd4});
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 8'hFE; bus.ext_len = 4'd3;
    for (int i = 0; i < 5; i++) begin
      bus.ext_wdata = 32'(i + 1);
      @(negedge clk);
      chk("wrburst_wready_done", {62'd0, bus.ext_wready, bus.ext_done}, (i < 4) ? 64'd2 : 64'd1);
      next_cycle();
    end
    bus.ext_req = 0;
    core_load(8'h00, 32'd3);

    // Fairness: core hammers while ext waits; 4 core wins then ext
    wr_q.push_back({8'h20, 32'hA0}); wr_q.push_back({8'h21, 32'hA1});
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 8'h20; bus.ext_len = 4'd1;
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h01;
    for (int i = 0; i < 7; i++) begin
      bus.ext_wdata = 32'hA0 + ((i >= 4) ? 32'(i - 4) : 32'd0);
      exp3 = (i < 4) ? 3'b100 : (i < 6) ? 3'b010 : 3'b101;
      @(negedge clk);
      chk("fair_gnt_wready_done", 64'({bus.core_gnt, bus.ext_wready, bus.ext_done}), 64'(exp3));
      if (bus.core_gnt) core_q.push_back(32'd4);
      next_cycle();
    end
    bus.ext_req = 0; bus.core_req = 0;

    // 16-beat ext read with a stalled core load
    for (int i = 0; i < 16; i++) ext_q.push_back(32'h130 + 32'(i));
    bus.ext_we = 0; bus.ext_addr = 8'h30; bus.ext_len = 4'd15;
    bus.core_we = 0; bus.core_addr = 8'h10;
    for (int i = 0; i < 18; i++) begin
      bus.ext_req  = (i <= 16);
      bus.core_req = (i >= 1 && i <= 16);
      exp3 = {i == 16, i >= 1 && i <= 16, i == 16};
      @(negedge clk);
      chk("rdburst_gnt_rv_done", 64'({bus.core_gnt, bus.ext_rvalid, bus.ext_done}), 64'(exp3));
      if (bus.core_gnt) core_q.push_back(32'hDEADBEEF);
      next_cycle();
    end
    bus.ext_req = 0; bus.core_req = 0;

    // Single-beat ext read forced through by win_cnt saturation
    ext_q.push_back(32'h135);
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 8'h35; bus.ext_len = 4'd0;
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h10;
    for (int i = 0; i < 6; i++) begin
      exp3 = (i < 4) ? 3'b100 : (i == 4) ? 3'b000 : 3'b111;
      @(negedge clk);
      chk("len0_gnt_rv_done", 64'({bus.core_gnt, bus.ext_rvalid, bus.ext_done}), 64'(exp3));
      if (i == 4) chk("len0_beat", {bus.mem_ren, bus.mem_raddr}, {1'b1, 8'h35});
      if (bus.core_gnt) core_q.push_back(32'hDEADBEEF);
      next_cycle();
    end
    bus.ext_req = 0; bus.core_req = 0;
    @(negedge clk);
    next_cycle();

    // Reset mid-way through a 16-beat write
    for (int i = 0; i < 5; i++) wr_q.push_back({8'h40 + 8'(i), 32'h200 + 32'(i)});
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 8'h40; bus.ext_len = 4'd15;
    for (int i = 0; i < 5; i++) begin
      bus.ext_wdata = 32'h200 + 32'(i);
      @(negedge clk);
      chk("abort_wready", 64'(bus.ext_wready), 64'd1);
      next_cycle();
    end
    rst_n = 0;
    bus.ext_req = 0;
    @(negedge clk);
    chk("abort_in_reset", 64'({bus.mem_wen, bus.ext_done, bus.ext_wready}), 64'd0);
    next_cycle();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 64'({bus.mem_wen, bus.ext_done, bus.ext_wready, bus.mem_ren}), 64'd0);
      next_cycle();
    end
    core_load(8'h10, 32'hDEADBEEF);

    repeat (2) next_cycle();
    chk("scoreboard_drained", 64'(wr_q.size() + core_q.size() + ext_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
